// File: rtl/serial_rx_decoder_if.sv
// Signal bundle between the serial calculator link/consumer and serial_rx_decoder.
// The master side drives the serial line and ACK; the slave side is the decoder.
interface serial_rx_decoder_if #(
  parameter int WIDTH = 16
);
  logic             D_OUT;
  logic             D_OUT_VALID;
  logic             CLK_Tx;
  logic             ACK;
  logic [WIDTH-1:0] DATA_OUT;
  logic             DATA_READY;
  logic             RX_BUSY;
  logic             FRAME_ERR;
  logic             OVERRUN;

  modport master (
    output D_OUT, D_OUT_VALID, CLK_Tx, ACK,
    input  DATA_OUT, DATA_READY, RX_BUSY, FRAME_ERR, OVERRUN
  );

  modport slave (
    input  D_OUT, D_OUT_VALID, CLK_Tx, ACK,
    output DATA_OUT, DATA_READY, RX_BUSY, FRAME_ERR, OVERRUN
  );
endinterface

// File: rtl/serial_rx_decoder.sv
// Deserialises MSB-first frames sampled on rising edges of CLK_Tx (as seen in the
// CLK domain) and holds the last complete word until the consumer acknowledges it.
module serial_rx_decoder #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  serial_rx_decoder_if.slave rx
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_LOW} state_t;

  state_t           state;
  logic             clk_tx_q;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt;
  logic             ready_q;
  logic             busy_q;
  logic             ferr_q;
  logic             ovr_q;

  logic             sample;
  logic             take;
  logic             done;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    cnt_next;

  // shreg and cnt are kept at zero outside SHIFT, so the same shift path loads bit 1.
  assign sample     = rx.CLK_Tx & ~clk_tx_q;
  assign take       = sample & rx.D_OUT_VALID & (state != WAIT_LOW);
  assign shift_next = (shreg << 1) | WIDTH'(rx.D_OUT);
  assign cnt_next   = cnt + CW'(1);
  assign done       = take & (cnt_next == LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      clk_tx_q <= 1'b0;
      shreg    <= '0;
      cnt      <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      clk_tx_q <= rx.CLK_Tx;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;

      if (ready_q && rx.ACK)
        ready_q <= 1'b0;

      // A completing frame takes priority over the ACK clear above.
      if (done) begin
        if (!ready_q || rx.ACK) begin
          data_q  <= shift_next;
          ready_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end

      case (state)
        IDLE, SHIFT: begin
          if (state == SHIFT && !rx.D_OUT_VALID) begin
            ferr_q <= 1'b1;
            shreg  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (done) begin
            shreg  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= WAIT_LOW;
          end else if (take) begin
            shreg  <= shift_next;
            cnt    <= cnt_next;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        WAIT_LOW: begin
          if (!rx.D_OUT_VALID)
            state <= IDLE;
        end
        default: begin
          shreg  <= '0;
          cnt    <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign rx.DATA_OUT   = data_q;
  assign rx.DATA_READY = ready_q;
  assign rx.RX_BUSY    = busy_q;
  assign rx.FRAME_ERR  = ferr_q;
  assign rx.OVERRUN    = ovr_q;

endmodule
